// File: rtl/logic_response_checker_if.sv
//------------------------------------------------------------------------------
// logic_response_checker_if
//
// Stimulus/response bundle between a stimulus source and the response checker
// of the Y = NOT A AND B stage.
//   sample_i      strobe: a_i/b_i are applied to the stage this cycle
//   a_i, b_i      applied input vector
//   y_i           observed output of the stage
//   check_valid_o one-cycle pulse when a comparison completes
//   check_pass_o  result of the last comparison
// The master modport is the stimulus side, the slave modport is the checker.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface logic_response_checker_if;
    logic sample_i;
    logic a_i;
    logic b_i;
    logic y_i;
    logic check_valid_o;
    logic check_pass_o;

    modport master (
        output sample_i, a_i, b_i, y_i,
        input  check_valid_o, check_pass_o
    );

    modport slave (
        input  sample_i, a_i, b_i, y_i,
        output check_valid_o, check_pass_o
    );
endinterface

// File: rtl/logic_response_checker.sv
//------------------------------------------------------------------------------
// logic_response_checker
//
// Response monitor for the Y = NOT A AND B stage. A sample strobe captures the
// applied {a,b}, waits SETTLE_CYCLES, samples y, compares it against ~a & b and
// records coverage of the four input combinations plus error statistics.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear_i             synchronous clear of all status and any in-flight check
//   rsp (slave)         sample_i/a_i/b_i/y_i in, check_valid_o/check_pass_o out
//   busy_o              check in progress (WAIT or CMP)
//   covered_o           bit {a,b} set once that combination has been checked
//   done_o              all four combinations covered
//   error_cnt_o         saturating count of failed comparisons
//   first_err_valid_o   at least one failure since reset/clear
//   first_err_vec_o     {a,b,y} of the first failed comparison
//   overrun_o           sticky: sample strobe seen while busy
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module logic_response_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,   // 0..15
    parameter int unsigned ERR_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    logic_response_checker_if.slave  rsp,
    output logic                     busy_o,
    output logic [3:0]               covered_o,
    output logic                     done_o,
    output logic [ERR_W-1:0]         error_cnt_o,
    output logic                     first_err_valid_o,
    output logic [2:0]               first_err_vec_o,
    output logic                     overrun_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CMP
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               valid_q, valid_d;
    logic               pass_q, pass_d;
    logic [3:0]         covered_q, covered_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               ferr_valid_q, ferr_valid_d;
    logic [2:0]         ferr_vec_q, ferr_vec_d;
    logic               overrun_q, overrun_d;

    logic               mismatch;

    assign mismatch = (rsp.y_i != (~a_q & b_q));

    always_comb begin
        // NOTE: every next-state value takes its hold value first so no path
        // through the case leaves a signal unassigned (which would infer a latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        valid_d      = 1'b0;
        pass_d       = pass_q;
        covered_d    = covered_q;
        err_d        = err_q;
        ferr_valid_d = ferr_valid_q;
        ferr_vec_d   = ferr_vec_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (rsp.sample_i) begin
                    a_d = rsp.a_i;
                    b_d = rsp.b_i;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = S_CMP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = SETTLE_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (rsp.sample_i) overrun_d = 1'b1;
                if (cnt_q == 4'd1) state_d = S_CMP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_CMP: begin
                if (rsp.sample_i) overrun_d = 1'b1;
                valid_d               = 1'b1;
                pass_d                = ~mismatch;
                covered_d[{a_q, b_q}] = 1'b1;
                if (mismatch) begin
                    // Saturate rather than wrap so a long failing run never reads as clean.
                    if (err_q != '1) err_d = err_q + ERR_W'(1);
                    if (!ferr_valid_q) begin
                        ferr_valid_d = 1'b1;
                        ferr_vec_d   = {a_q, b_q, rsp.y_i};
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Clear overrides everything, including a strobe in the same cycle.
        if (clear_i) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            a_d          = 1'b0;
            b_d          = 1'b0;
            valid_d      = 1'b0;
            pass_d       = 1'b0;
            covered_d    = '0;
            err_d        = '0;
            ferr_valid_d = 1'b0;
            ferr_vec_d   = '0;
            overrun_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            valid_q      <= 1'b0;
            pass_q       <= 1'b0;
            covered_q    <= '0;
            err_q        <= '0;
            ferr_valid_q <= 1'b0;
            ferr_vec_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            valid_q      <= valid_d;
            pass_q       <= pass_d;
            covered_q    <= covered_d;
            err_q        <= err_d;
            ferr_valid_q <= ferr_valid_d;
            ferr_vec_q   <= ferr_vec_d;
            overrun_q    <= overrun_d;
        end
    end

    assign busy_o            = (state_q != S_IDLE);
    assign rsp.check_valid_o = valid_q;
    assign rsp.check_pass_o  = pass_q;
    assign covered_o         = covered_q;
    assign done_o            = &covered_q;
    assign error_cnt_o       = err_q;
    assign first_err_valid_o = ferr_valid_q;
    assign first_err_vec_o   = ferr_vec_q;
    assign overrun_o         = overrun_q;

endmodule
